shift_sequencer: RTL and testbench



---
 rtl/shift_pkg.sv | 20 ++
 rtl/shift_step_core.sv | 51 +++++
 rtl/shift_sequencer.sv | 99 +++++++++
 tb/tb_shift_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared encodings and default geometry for the shift sequencer and its datapath.
package shift_pkg;

  localparam int DEF_WIDTH = 128;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    MODE_LSL = 2'b00,
    MODE_LSR = 2'b01,
    MODE_ASR = 2'b10,
    MODE_ROL = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step_core.sv
// Registered WIDTH-bit shifter: load wins over step, one bit position per enabled edge.
// Latency one edge per step; no handshake, the sequencer owns flow control.
module shift_step_core
  import shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_dat_i,
  input  logic             step_i,
  input  logic [1:0]       mode_i,
  output logic [WIDTH-1:0] dat_o
);

  logic [WIDTH-1:0] reg_q;
  logic [WIDTH-1:0] reg_d;
  logic [WIDTH-1:0] stepped;

  always_comb begin
    stepped = reg_q;
    case (mode_e'(mode_i))
      MODE_LSL: stepped = {reg_q[WIDTH-2:0], 1'b0};
      MODE_LSR: stepped = {1'b0, reg_q[WIDTH-1:1]};
      MODE_ASR: stepped = {reg_q[WIDTH-1], reg_q[WIDTH-1:1]};
      MODE_ROL: stepped = {reg_q[WIDTH-2:0], reg_q[WIDTH-1]};
      default:  stepped = reg_q;
    endcase
  end

  always_comb begin
    reg_d = reg_q;
    if (load_i) begin
      reg_d = load_dat_i;
    end else if (step_i) begin
      reg_d = stepped;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      reg_q <= '0;
    end else begin
      reg_q <= reg_d;
    end
  end

  assign dat_o = reg_q;

endmodule

// File: rtl/shift_sequencer.sv
// Command-driven sequencer: accepts load/amount/mode, steps the shifter one bit per clock, returns result.
// Result N=min(amount,WIDTH) edges after accept; held in DONE until res_ready, then one idle bubble.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_amount,
  input  logic [1:0]       cmd_mode,
  input  logic             abort,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             busy
);

  localparam logic [CNT_W-1:0] WIDTH_CNT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mode_e            mode_q, mode_d;
  logic [CNT_W-1:0] amt_clamped;
  logic             load;
  logic             step;

  assign amt_clamped = (cmd_amount > WIDTH_CNT) ? WIDTH_CNT : cmd_amount;

  assign cmd_ready = (state_q == IDLE) && !reset;
  assign res_valid = (state_q == DONE);
  assign busy      = (state_q == SHIFT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          load    = 1'b1;
          mode_d  = mode_e'(cmd_mode);
          cnt_d   = amt_clamped;
          state_d = (amt_clamped == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        // Abort freezes the partially shifted word rather than taking one more step.
        if (abort) begin
          state_d = IDLE;
        end else begin
          step  = 1'b1;
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= MODE_LSL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  shift_step_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clock      (clock),
    .reset      (reset),
    .load_i     (load),
    .load_dat_i (cmd_data),
    .step_i     (step),
    .mode_i     (mode_q),
    .dat_o      (res_data)
  );

endmodule

// File: tb/tb_shift_sequencer.sv
// Scenario bench for shift_sequencer: expected words queued at command time, popped on result handshake.
module tb_shift_sequencer;
  import shift_pkg::*;

  localparam int W  = 128;
  localparam int CW = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [W-1:0]  cmd_data;
  logic [CW-1:0] cmd_amount;
  logic [1:0]    cmd_mode;
  logic          abort;
  logic          res_valid;
  logic          res_ready;
  logic [W-1:0]  res_data;
  logic          busy;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  shift_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_data   (cmd_data),
    .cmd_amount (cmd_amount),
    .cmd_mode   (cmd_mode),
    .abort      (abort),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Whole-amount reference using native shift operators.
  function automatic logic [W-1:0] model(input logic [W-1:0] d, input int amt, input logic [1:0] m);
    int n;
    n = (amt > W) ? W : amt;
    case (m)
      2'b00:   return d << n;
      2'b01:   return d >> n;
      2'b10:   return W'($signed(d) >>> n);
      default: return (d << n) | (d >> (W - n));
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input int amt, input logic [1:0] m, input string name);
    bit ok;
    ok         = 1'b0;
    cmd_data   = d;
    cmd_amount = CW'(amt);
    cmd_mode   = m;
    cmd_valid  = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (cmd_ready) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    cmd_valid = 1'b0;
    total++;
    if (ok !== 1'b1) begin
      bad++;
      $display("FAIL %s accept: cmd_ready never seen, got=%0b want=1", name, ok);
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!res_valid && lat < 300) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_cmd(input logic [W-1:0] d, input int amt, input logic [1:0] m, input string name);
    int lat;
    int want_lat;
    logic [W-1:0] want;
    want_lat  = (amt > W) ? W : amt;
    res_ready = 1'b1;
    exp_q.push_back(model(d, amt, m));
    send(d, amt, m, name);
    wait_valid(lat);
    total++;
    if (lat !== want_lat) begin
      bad++;
      $display("FAIL %s latency: got=%0d want=%0d", name, lat, want_lat);
    end
    total++;
    if (cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s bubble cmd_ready: got=%0b want=0", name, cmd_ready);
    end
    if (res_valid && exp_q.size() > 0) begin
      want = exp_q.pop_front();
      total++;
      if (res_data !== want) begin
        bad++;
        $display("FAIL %s data: got=%h want=%h", name, res_data, want);
      end
    end else begin
      exp_q.delete();
    end
    tick();
    total++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s return to idle: res_valid=%0b cmd_ready=%0b want 0/1", name, res_valid, cmd_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++;
    if (cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset cmd_ready_in_reset: got=%0b want=0", cmd_ready);
    end
    total++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || res_data !== '0) begin
      bad++;
      $display("FAIL reset outputs: res_valid=%0b busy=%0b res_data=%h want 0/0/0", res_valid, busy, res_data);
    end
    reset = 1'b0;
    #1;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset cmd_ready_after: got=%0b want=1", cmd_ready);
    end
    // Mid-shift reset: the fourth step edge is replaced by a reset edge.
    res_ready = 1'b0;
    send(128'hABCD_0000_1234, 10, MODE_LSL, "reset_mid");
    tick();
    tick();
    tick();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid busy_before: got=%0b want=1", busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || res_data !== '0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid state: busy=%0b res_valid=%0b res_data=%h cmd_ready=%0b want 0/0/0/1",
               busy, res_valid, res_data, cmd_ready);
    end
  endtask

  task automatic test_lsl_hold();
    int lat;
    logic [W-1:0] want;
    res_ready = 1'b0;
    exp_q.push_back(model(128'h1, 3, MODE_LSL));
    send(128'h1, 3, MODE_LSL, "lsl_hold");
    wait_valid(lat);
    total++;
    if (lat !== 3) begin
      bad++;
      $display("FAIL lsl_hold latency: got=%0d want=3", lat);
    end
    want = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      total++;
      if (res_valid !== 1'b1 || res_data !== 128'h8 || res_data !== want) begin
        bad++;
        $display("FAIL lsl_hold hold[%0d]: res_valid=%0b res_data=%h want 1/%h", i, res_valid, res_data, want);
      end
      tick();
    end
    total++;
    if (cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL lsl_hold bubble: cmd_ready=%0b want=0", cmd_ready);
    end
    res_ready = 1'b1;
    tick();
    total++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL lsl_hold idle: res_valid=%0b cmd_ready=%0b want 0/1", res_valid, cmd_ready);
    end
  endtask

  task automatic test_modes();
    run_cmd(128'h8000_0000_0000_0000_0000_0000_0000_0001, 1, MODE_ASR, "asr1");
    run_cmd(128'h8000_0000_0000_0000_0000_0000_0000_0001, 1, MODE_LSR, "lsr1");
    run_cmd(128'h8000_0000_0000_0000_0000_0000_0000_0001, 1, MODE_ROL, "rol1");
    run_cmd(128'h8000_0000_0000_0000_0000_0000_0000_0001, 1, MODE_LSL, "lsl1");
    run_cmd(128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE, 7, MODE_ROL, "rol7");
  endtask

  task automatic test_boundary();
    run_cmd(128'h1357_9BDF_2468_ACE0_FFFF_0000_A5A5_5A5A, 0, MODE_ASR, "amt0");
    run_cmd({W{1'b1}}, 200, MODE_LSL, "lsl200");
    run_cmd(128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0, 200, MODE_ROL, "rol200");
    run_cmd(128'h8000_0000_0000_0000_0000_0000_0000_1234, 200, MODE_ASR, "asr200");
    run_cmd(128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000, 128, MODE_LSR, "lsr128");
  endtask

  task automatic test_abort();
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] partial;
    x = 128'h0000_0000_0000_0000_0000_0000_00C0_FFEE;
    y = 128'h5555_AAAA_5555_AAAA_1111_2222_3333_4444;
    partial = x << 4;
    res_ready = 1'b1;
    send(x, 20, MODE_LSL, "abort");
    for (int i = 0; i < 4; i++) begin
      total++;
      if (res_valid !== 1'b0) begin
        bad++;
        $display("FAIL abort early_valid[%0d]: got=%0b want=0", i, res_valid);
      end
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL abort idle: busy=%0b res_valid=%0b cmd_ready=%0b want 0/0/1", busy, res_valid, cmd_ready);
    end
    total++;
    if (res_data !== partial) begin
      bad++;
      $display("FAIL abort partial: got=%h want=%h", res_data, partial);
    end
    send(y, 0, MODE_LSL, "abort_next");
    total++;
    if (res_valid !== 1'b1 || res_data !== y) begin
      bad++;
      $display("FAIL abort_next result: res_valid=%0b res_data=%h want 1/%h", res_valid, res_data, y);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] want;
    int accepts;
    int results;
    bit acc_now;
    a = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    b = 128'hF000_0000_0000_0000_0000_0000_0000_000F;
    accepts = 0;
    results = 0;
    res_ready  = 1'b1;
    cmd_data   = a;
    cmd_amount = CW'(5);
    cmd_mode   = MODE_LSL;
    cmd_valid  = 1'b1;
    exp_q.push_back(model(a, 5, MODE_LSL));
    for (int c = 0; c < 200 && results < 2; c++) begin
      acc_now = cmd_valid && cmd_ready;
      if (acc_now) begin
        total++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
          bad++;
          $display("FAIL b2b accept_outside_idle: busy=%0b res_valid=%0b want 0/0", busy, res_valid);
        end
      end
      if (res_valid && res_ready && exp_q.size() > 0) begin
        want = exp_q.pop_front();
        total++;
        if (res_data !== want) begin
          bad++;
          $display("FAIL b2b result[%0d]: got=%h want=%h", results, res_data, want);
        end
        results++;
      end
      tick();
      if (acc_now) begin
        accepts++;
        if (accepts == 1) begin
          cmd_data   = b;
          cmd_amount = CW'(2);
          cmd_mode   = MODE_ROL;
          exp_q.push_back(model(b, 2, MODE_ROL));
        end else begin
          cmd_valid = 1'b0;
        end
      end
    end
    cmd_valid = 1'b0;
    total++;
    if (results !== 2) begin
      bad++;
      $display("FAIL b2b result_count: got=%0d want=2", results);
    end
    exp_q.delete();
    tick();
  endtask

  initial begin
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_data   = '0;
    cmd_amount = '0;
    cmd_mode   = 2'b00;
    abort      = 1'b0;
    res_ready  = 1'b0;
    test_reset();
    test_lsl_hold();
    test_modes();
    test_boundary();
    test_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
